// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg -- shared types for the immediate-extension stage.
//   mode_e  : extension mode carried on in_mode (SIGN, ZERO, HIGH, RSVD)
//   state_e : occupancy of the 2-entry output FIFO (EMPTY, ONE, FULL)
package imm_ext_pkg;

   typedef enum logic [1:0] {
      SIGN = 2'b00,
      ZERO = 2'b01,
      HIGH = 2'b10,
      RSVD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core -- combinational immediate extender.
//   in_data  [IN_W]  : raw immediate
//   in_mode  [2]     : SIGN / ZERO / HIGH / RSVD (RSVD behaves as SIGN)
//   ext_data [OUT_W] : extended word
// Build option: IMM_EXT_HIGH_EN -- when defined, HIGH places the immediate in
// the upper bits; when undefined, HIGH behaves as ZERO and no shifter exists.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic [OUT_W-1:0] ext_data
);

   localparam int PAD_W = OUT_W - IN_W;

   mode_e mode;
   assign mode = mode_e'(in_mode);

   always_comb begin
      // SIGN and the reserved encoding share the default path
      ext_data = {{PAD_W{in_data[IN_W-1]}}, in_data};
      case (mode)
         ZERO: ext_data = {{PAD_W{1'b0}}, in_data};
`ifdef IMM_EXT_HIGH_EN
         HIGH: ext_data = {{PAD_W{1'b0}}, in_data} << PAD_W;
`else
         HIGH: ext_data = {{PAD_W{1'b0}}, in_data};
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage -- one-cycle immediate-extension pipeline stage with a
// 2-entry in-order output FIFO and valid/ready handshakes on both sides.
//   clk, rst_n (async, active-low), flush (sync, highest priority)
//   in_valid / in_ready / in_data[IN_W] / in_mode[2]  : upstream beat
//   out_valid / out_ready / out_data[OUT_W]           : extended result
// Build option: IMM_EXT_HIGH_EN (see imm_ext_core) enables mode HIGH.
module imm_ext_stage
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   logic [OUT_W-1:0] ext_w;

   // Extension happens at accept time; buffered entries never re-evaluate.
   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .in_data  (in_data),
      .in_mode  (in_mode),
      .ext_data (ext_w)
   );

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] head_q, head_d;
   logic [OUT_W-1:0] tail_q, tail_d;
   logic             push, pop;

   assign push = in_valid && in_ready_q && !flush;
   assign pop  = out_valid_q && out_ready && !flush;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               head_d  = ext_w;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               // old head leaves this edge, so the new beat becomes head
               head_d = ext_w;
            end else if (push) begin
               tail_d  = ext_w;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low in FULL, so only a pop can occur here
            if (pop) begin
               head_d  = tail_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
      // handshake outputs are registered copies of the next-state decode,
      // so in_ready has no combinational path from out_ready
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Storage is qualified by state, so it needs no reset.
   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_valid_q ? head_q : '0;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   logic [31:0] exp_in;
   logic [31:0] sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

`ifdef IMM_EXT_HIGH_EN
   localparam logic [31:0] EXP_HIGH = 32'h1234_0000;
`else
   localparam logic [31:0] EXP_HIGH = 32'h0000_1234;
`endif

   imm_ext_stage #(.IN_W(16), .OUT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: accepted beats push their expected result, consumed
   // results are popped and compared in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (flush) begin
            sb.delete();
         end else begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", out_data, 32'hxxxx_xxxx);
               end else begin
                  check("sb_out_data", out_data, sb.pop_front());
               end
            end
            if (in_valid && in_ready) begin
               sb.push_back(exp_in);
            end
         end
         if (!out_valid) begin
            check("idle_out_data_zero", out_data, 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      exp_in   = e;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("send_timeout", 32'(waited), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      in_mode  = 2'b10;
   endtask

   initial begin
      rst_n     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      in_mode   = 2'b00;
      out_ready = 1'b1;
      exp_in    = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      step();
      step();
      rst_n = 1'b1;

      // single beat: one-cycle latency, SIGN mode
      send(16'h8001, 2'b00, 32'hFFFF_8001);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      check("latency_out_data", out_data, 32'hFFFF_8001);
      step();
      check("drained_out_valid", 32'(out_valid), 32'd0);

      // back-to-back stream through all modes
      send(16'h8001, 2'b01, 32'h0000_8001);
      send(16'h1234, 2'b10, EXP_HIGH);
      send(16'hFFFF, 2'b11, 32'hFFFF_FFFF);
      send(16'h7FFF, 2'b00, 32'h0000_7FFF);
      send(16'h0080, 2'b01, 32'h0000_0080);
      send(16'h8000, 2'b11, 32'hFFFF_8000);
      step();
      step();

      // fill to FULL, hold a third beat, then release in order
      out_ready = 1'b0;
      send(16'h0001, 2'b01, 32'h0000_0001);
      send(16'h0002, 2'b01, 32'h0000_0002);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_head", out_data, 32'h0000_0001);
      fork
         send(16'h0003, 2'b01, 32'h0000_0003);
         begin
            repeat (3) step();
            check("held_in_ready", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
         end
      join
      step();
      step();

      // ONE with simultaneous push and pop stays ONE, new beat becomes head
      out_ready = 1'b0;
      send(16'h0009, 2'b01, 32'h0000_0009);
      out_ready = 1'b1;
      send(16'h0005, 2'b01, 32'h0000_0005);
      out_ready = 1'b0;
      check("pushpop_in_ready", 32'(in_ready), 32'd1);
      check("pushpop_out_data", out_data, 32'h0000_0005);
      out_ready = 1'b1;
      step();
      step();

      // flush in ONE with a same-cycle beat
      out_ready = 1'b0;
      send(16'h0011, 2'b01, 32'h0000_0011);
      in_valid = 1'b1; in_data = 16'h0022; in_mode = 2'b01; exp_in = 32'h0000_0022;
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush1_out_valid", 32'(out_valid), 32'd0);
      check("flush1_in_ready", 32'(in_ready), 32'd1);

      // flush in FULL with a same-cycle beat
      send(16'h000A, 2'b01, 32'h0000_000A);
      send(16'h000B, 2'b01, 32'h0000_000B);
      in_valid = 1'b1; in_data = 16'h000C; in_mode = 2'b01; exp_in = 32'h0000_000C;
      flush = 1'b1;
      out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush2_out_valid", 32'(out_valid), 32'd0);
      check("flush2_out_data", out_data, 32'h0);
      check("flush2_in_ready", 32'(in_ready), 32'd1);
      repeat (4) step();

      // async reset mid-cycle while FULL
      out_ready = 1'b0;
      send(16'h0001, 2'b01, 32'h0000_0001);
      send(16'h0002, 2'b01, 32'h0000_0002);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_data", out_data, 32'h0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'h7FFF, 2'b01, 32'h0000_7FFF);
      check("post_rst_out_data", out_data, 32'h0000_7FFF);

      // drain, bounded
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      step();
      check("sb_empty_at_end", 32'(sb.size()), 32'd0);
      check("end_out_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
